// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   hilo_op_t      - issue opcode carried on op_i
//   muldiv_state_t - control FSM states
//   HILO_WE_*      - write-enable encodings for hilo_we_o (bit1 = HI, bit0 = LO)
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// div_iter: unsigned restoring radix-2 divider core, one quotient bit per step.
//   clk_i, rst_i   - clock, async active-high reset
//   load_i         - capture dividend/divisor, clear partial remainder and step count
//   step_i         - perform one iteration
//   dividend_i     - unsigned dividend magnitude
//   divisor_i      - unsigned divisor magnitude
//   last_o         - the current step is the WIDTH-th (final) one
//   quo_nxt_o      - quotient after the current step
//   rem_nxt_o      - partial remainder after the current step
// The *_nxt outputs let the owner capture the final result on the same edge
// that performs the last step, so no extra cycle is spent on readout.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_nxt_o,
  output logic [WIDTH-1:0] rem_nxt_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // Quotient register doubles as the dividend shift register: its MSB feeds
  // the partial remainder, the new quotient bit enters at the LSB.
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign fits      = shifted >= {1'b0, dvs_q};
  // Partial remainder always stays below the divisor, so WIDTH bits suffice.
  assign rem_nxt_o = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : WIDTH'(shifted);
  assign quo_nxt_o = {quo_q[WIDTH-2:0], fits};
  assign last_o    = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: EX-stage multi-cycle HI/LO producer (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//   clk_i, rst_i  - clock, async active-high reset
//   flush_i       - pipeline flush, aborts any operation and suppresses the write
//   start_i, op_i - issue request and opcode (hilo_op_t)
//   src_a_i       - rs: dividend / multiplicand / MTHI-MTLO data
//   src_b_i       - rt: divisor / multiplier
//   stall_o       - hold ID/EX while a multiply/divide is in flight
//   valid_o       - one-cycle result pulse
//   hilo_we_o     - {write HI, write LO}
//   hi_o, lo_o    - registered HI/LO write data (hold between results)
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [1:0]       hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  muldiv_state_t state_q, state_d;
  hilo_op_t      op;

  logic accept, is_mul, is_div, is_mt, div_sgn;

  logic [WIDTH-1:0]   opa_q, opb_q, hi_q, lo_q;
  logic               mul_sgn_q, sign_q_q, sign_r_q, div_zero_q;
  logic [1:0]         we_q;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic               div_last;

  assign op      = hilo_op_t'(op_i);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt   = (op == OP_MTHI) || (op == OP_MTLO);
  assign div_sgn = (op == OP_DIV);
  assign accept  = (state_q == ST_IDLE) && start_i && !flush_i;

  // Divider works on magnitudes; signs are restored after the last step.
  assign abs_a = (div_sgn && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign abs_b = (div_sgn && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

  // Sign/zero extension to 2*WIDTH lets one unsigned multiplier cover both
  // MULT and MULTU; the low 2*WIDTH bits of the product are exact either way.
  assign ext_a = {{WIDTH{mul_sgn_q & opa_q[WIDTH-1]}}, opa_q};
  assign ext_b = {{WIDTH{mul_sgn_q & opb_q[WIDTH-1]}}, opb_q};
  assign prod  = ext_a * ext_b;

  assign quo_fix = sign_q_q ? -quo_nxt : quo_nxt;
  assign rem_fix = sign_r_q ? -rem_nxt : rem_nxt;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && is_div),
    .step_i     (state_q == ST_DIV),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .last_o     (div_last),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          if (is_mul)      state_d = ST_MUL;
          else if (is_div) state_d = ST_DIV;
          else if (is_mt)  state_d = ST_DONE;
        end
        ST_MUL:  state_d = ST_DONE;
        ST_DIV:  if (div_last) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: a flush in the DONE cycle kills the write.
  always_comb begin
    stall_o   = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                (accept && (is_mul || is_div));
    valid_o   = (state_q == ST_DONE) && !flush_i;
    hilo_we_o = valid_o ? we_q : HILO_WE_NONE;
  end

  // Operand capture and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opa_q      <= '0;
      opb_q      <= '0;
      mul_sgn_q  <= 1'b0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      we_q       <= HILO_WE_NONE;
    end else begin
      if (accept) begin
        opa_q      <= src_a_i;
        opb_q      <= src_b_i;
        mul_sgn_q  <= (op == OP_MULT);
        sign_q_q   <= div_sgn && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
        sign_r_q   <= div_sgn && src_a_i[WIDTH-1];
        div_zero_q <= (src_b_i == '0);
        if (op == OP_MTHI) begin
          hi_q <= src_a_i;
          lo_q <= '0;
          we_q <= HILO_WE_HI;
        end else if (op == OP_MTLO) begin
          hi_q <= '0;
          lo_q <= src_a_i;
          we_q <= HILO_WE_LO;
        end
      end
      if (state_q == ST_MUL && !flush_i) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
        we_q <= HILO_WE_BOTH;
      end
      if (state_q == ST_DIV && div_last && !flush_i) begin
        // Divide by zero reports the original dividend, unsigned-style.
        if (div_zero_q) begin
          hi_q <= opa_q;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
        we_q <= HILO_WE_BOTH;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
